add_sub_result_window_accum: RTL
================================

// Module: add_sub_result_window_accum
// PURPOSE
//  Downstream consumer of the 8-bit add/sub result stage. Accepts results over a
//  valid/ready stream and sums WINDOW of them, or fewer if closed early by in_last.
//  Presents one summary beat per window: sum, sample count, min, max and overflow.
//  Holds that beat under backpressure, then clears and starts the next window.
// PARAMETERS
//  DATA_W     8   width of each incoming result sample
//  WINDOW     16  samples per window (>=2); window also closes early on in_last
//  SUM_W      16  accumulator/out_sum width; sum wraps modulo 2^SUM_W
//  SIGNED_IN  0   0: unsigned samples, zero-extend, unsigned min/max;
//                 1: two's complement, sign-extend, signed min/max
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               asynchronous, active-high reset
//  in_valid   in   1               in_data/in_last valid
//  in_ready   out  1               block accepts a sample this cycle
//  in_data    in   DATA_W          result sample from the add/sub stage
//  in_last    in   1               qualified by in_valid; closes the window after this sample
//  out_valid  out  1               summary beat valid
//  out_ready  in   1               consumer accepts the summary beat
//  out_sum    out  SUM_W           wrapped sum of the window's samples
//  out_count  out  $clog2(WINDOW+1) number of samples in the window (1..WINDOW)
//  out_min    out  DATA_W          smallest sample in the window
//  out_max    out  DATA_W          largest sample in the window
//  out_ovf    out  1               sticky: at least one add in the window over/underflowed SUM_W
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): state=IDLE. All outputs and
//    accumulators 0; in_ready=0; out_valid=0.
//  - FSM IDLE->ACCUM->HOLD->ACCUM. All outputs are registered.
//    in_ready = (state==ACCUM). out_valid = (state==HOLD).
//  - IDLE: lasts exactly 1 cycle after reset release, then ACCUM.
//  - ACCUM: a beat is accepted on in_valid&in_ready; in_valid alone is ignored.
//    On accept: sum += ext(in_data); count++.
//    First sample of the window loads min and max. Later samples update min/max
//    by compare (signed when SIGNED_IN=1).
//    ovf |= carry-out of bit SUM_W (unsigned) or signed overflow (SIGNED_IN=1).
//  - Window closes on the accepted beat where count+1==WINDOW or in_last=1,
//    whichever comes first. Next cycle is HOLD, with out_* showing final values
//    including that beat. Latency: last accepted beat -> out_valid = 1 cycle.
//  - HOLD: out_* stable while out_ready=0, for any number of cycles.
//    No samples are accepted.
//    On out_valid&out_ready: clear sum/count/min/max/ovf and go to ACCUM.
//    in_ready rises the following cycle (1 bubble per window, by design).
//  - out_* keep their last values after the handshake until the next window
//    closes. Consumers qualify them with out_valid.
//  - in_last on a beat that also fills WINDOW: a single close, count=WINDOW.
//  - Reset mid-window or mid-HOLD discards the partial window or pending beat.
//    Nothing from before reset is ever emitted.
// STRUCTURE
//  - Shared package add_sub_pkg: FSM state encoding (IDLE/ACCUM/HOLD), default
//    DATA_W/WINDOW/SUM_W constants, and the count-width function ($clog2(WINDOW+1)).
//  - One sub-module, window_minmax_track: tracks min/max with load-on-first,
//    a clear input and a SIGNED_IN parameter. Sum, count and FSM stay in the top.
// TESTING
//  1. rst held 3 cycles, then released -> all out_* 0, in_ready 0 during reset and
//     in the first cycle after release, 1 from the 2nd cycle.
//  2. WINDOW=4, SIGNED_IN=0: samples 10,20,30,40 back-to-back -> 1 cycle after the
//     4th: out_valid=1, sum=100, count=4, min=10, max=40, ovf=0.
//  3. Samples 0xFF, then 0x01 with in_last=1 -> sum=256, count=2, min=0x01,
//     max=0xFF; next window starts empty.
//  4. Window closed, out_ready=0 for 5 cycles while in_valid=1 -> out_* constant,
//     in_ready=0, no sample consumed. out_ready=1 -> in_ready=1 the next cycle,
//     and the new window sums only samples after that.
//  5. SIGNED_IN=1, SUM_W=8: 0x80 then 0x05 with in_last -> sum=0x85, min=0x80,
//     max=0x05, ovf=0. Separately 0x7F, 0x7F with in_last -> sum=0xFE, ovf=1.
//  6. rst pulsed after 2 of 4 samples (5,6), then 1,2,3,4 -> out_sum=10,
//     out_count=4; pre-reset samples never appear.

Source files
------------

// File: rtl/add_sub_result_window_accum_pkg.sv
// add_sub_pkg: shared FSM encoding, default widths and count-width helper
package add_sub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;
  localparam int DATA_W_DEF = 8;
  localparam int WINDOW_DEF = 16;
  localparam int SUM_W_DEF = 16;
  function automatic int cnt_w(input int window);
    return $clog2(window + 1);
  endfunction
endpackage

// File: rtl/add_sub_result_window_accum_minmax.sv
// window_minmax_track: running min/max of a window, first sample loads both
module window_minmax_track #(
  parameter int DATA_W = 8,
  parameter bit SIGNED_IN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              upd,
  input  logic              first,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] nxt_min,
  output logic [DATA_W-1:0] nxt_max
);
  logic [DATA_W-1:0] min_q, max_q;
  logic lt, gt;
  // candidate min/max including the current sample, so the caller can latch them on close
  always_comb begin
    lt = SIGNED_IN ? ($signed(data) < $signed(min_q)) : (data < min_q);
    gt = SIGNED_IN ? ($signed(data) > $signed(max_q)) : (data > max_q);
    nxt_min = (first || lt) ? data : min_q;
    nxt_max = (first || gt) ? data : max_q;
  end
  // track registers: cleared between windows, updated on each accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else if (clr) begin
      min_q <= '0;
      max_q <= '0;
    end else if (upd) begin
      min_q <= nxt_min;
      max_q <= nxt_max;
    end
  end
endmodule

// File: rtl/add_sub_result_window_accum.sv
// add_sub_result_window_accum: per-window sum/count/min/max/overflow summary over valid/ready
module add_sub_result_window_accum
  import add_sub_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WINDOW = WINDOW_DEF,
  parameter int SUM_W = SUM_W_DEF,
  parameter bit SIGNED_IN = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SUM_W-1:0]          out_sum,
  output logic [cnt_w(WINDOW)-1:0]  out_count,
  output logic [DATA_W-1:0]         out_min,
  output logic [DATA_W-1:0]         out_max,
  output logic                      out_ovf
);
  localparam int CW = cnt_w(WINDOW);
  state_t state, state_nxt;
  logic [SUM_W-1:0] sum_q, ext, sum_nxt;
  logic [CW-1:0] count_q;
  logic ovf_q, carry, ovf_bit, accept, close, fire;
  logic [DATA_W-1:0] nxt_min, nxt_max;
  // extend the sample, add, and flag carry-out or signed overflow for this add
  always_comb begin
    ext = SIGNED_IN ? SUM_W'($signed(in_data)) : SUM_W'(in_data);
    {carry, sum_nxt} = {1'b0, sum_q} + {1'b0, ext};
    ovf_bit = SIGNED_IN ? ((sum_q[SUM_W-1] == ext[SUM_W-1]) && (sum_nxt[SUM_W-1] != sum_q[SUM_W-1])) : carry;
    accept = in_valid && in_ready;
    close = accept && (in_last || count_q == CW'(WINDOW - 1));
    fire = out_valid && out_ready;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // next state: one idle cycle, accumulate until close, hold until the summary is taken
  always_comb begin
    state_nxt = state == IDLE  ? ACCUM :
                state == ACCUM ? (close ? HOLD : ACCUM) :
                state == HOLD  ? (fire ? ACCUM : HOLD) : IDLE;
  end
  // handshake outputs decoded straight from the state register
  always_comb begin
    in_ready = state == ACCUM;
    out_valid = state == HOLD;
  end
  // accumulators: clear when the summary is taken, update on every accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else if (fire) begin
      sum_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      sum_q <= sum_nxt;
      count_q <= count_q + CW'(1);
      ovf_q <= ovf_q | ovf_bit;
    end
  end
  // summary registers latch the final values on close and persist past the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum <= '0;
      out_count <= '0;
      out_min <= '0;
      out_max <= '0;
      out_ovf <= 1'b0;
    end else if (close) begin
      out_sum <= sum_nxt;
      out_count <= count_q + CW'(1);
      out_min <= nxt_min;
      out_max <= nxt_max;
      out_ovf <= ovf_q | ovf_bit;
    end
  end
  window_minmax_track #(.DATA_W(DATA_W), .SIGNED_IN(SIGNED_IN)) u_minmax (
    .clk(clk),
    .rst(rst),
    .clr(fire),
    .upd(accept),
    .first(count_q == '0),
    .data(in_data),
    .nxt_min(nxt_min),
    .nxt_max(nxt_max)
  );
endmodule
